// File: rtl/button_debounce_pulse_if.sv
// Button front-end signal bundle: raw pad input towards the debouncer and
// the conditioned level and pulses back to the stopwatch control logic.
interface button_debounce_pulse_if;
    logic btn_in;
    logic press_pulse;
    logic long_pulse;
    logic btn_level;

    modport master (
        output btn_in,
        input  press_pulse,
        input  long_pulse,
        input  btn_level
    );

    modport slave (
        input  btn_in,
        output press_pulse,
        output long_pulse,
        output btn_level
    );
endinterface

// File: rtl/button_debounce_pulse.sv
// Push-button front end: 2-flop synchroniser, press/release debounce FSM,
// one-cycle press pulse and a once-per-press long-hold pulse.
module button_debounce_pulse #(
    parameter int DB_CYCLES   = 400000,
    parameter int LONG_CYCLES = 40000000,
    parameter int CNT_W       = 26
) (
    input  logic                     clk,
    input  logic                     reset,
    button_debounce_pulse_if.slave   btn
);

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        PRESS_CHK   = 2'd1,
        PRESSED     = 2'd2,
        RELEASE_CHK = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

    state_t           state;
    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] db_cnt;
    logic [CNT_W-1:0] hold_cnt;
    logic             long_done;

    logic held;
    logic rel_accept;
    logic long_fire;

    // The hold window spans release-bounce checks; a release accepted on the
    // very edge the hold expires wins, so no long pulse follows a release.
    assign held       = (state == PRESSED) || (state == RELEASE_CHK);
    assign rel_accept = (state == RELEASE_CHK) && !s2 && (db_cnt == DB_LAST);
    assign long_fire  = held && !rel_accept && !long_done && (hold_cnt == LONG_LAST);

    // NOTE: every register here, outputs included, updates with non-blocking
    // assignments so all reads in this block see the pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1              <= 1'b0;
            s2              <= 1'b0;
            state           <= RELEASED;
            db_cnt          <= '0;
            hold_cnt        <= '0;
            long_done       <= 1'b0;
            btn.press_pulse <= 1'b0;
            btn.long_pulse  <= 1'b0;
            btn.btn_level   <= 1'b0;
        end else begin
            s1              <= btn.btn_in;
            s2              <= s1;
            btn.press_pulse <= 1'b0;
            btn.long_pulse  <= long_fire;

            if (held && (hold_cnt != LONG_LAST)) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
            if (long_fire) begin
                long_done <= 1'b1;
            end

            case (state)
                RELEASED: begin
                    btn.btn_level <= 1'b0;
                    if (s2) begin
                        state  <= PRESS_CHK;
                        db_cnt <= '0;
                    end
                end

                PRESS_CHK: begin
                    if (!s2) begin
                        state         <= RELEASED;
                        btn.btn_level <= 1'b0;
                    end else if (db_cnt == DB_LAST) begin
                        state           <= PRESSED;
                        hold_cnt        <= '0;
                        long_done       <= 1'b0;
                        btn.press_pulse <= 1'b1;
                        btn.btn_level   <= 1'b1;
                    end else begin
                        db_cnt        <= db_cnt + 1'b1;
                        btn.btn_level <= 1'b0;
                    end
                end

                PRESSED: begin
                    btn.btn_level <= 1'b1;
                    if (!s2) begin
                        state  <= RELEASE_CHK;
                        db_cnt <= '0;
                    end
                end

                RELEASE_CHK: begin
                    if (s2) begin
                        state         <= PRESSED;
                        btn.btn_level <= 1'b1;
                    end else if (db_cnt == DB_LAST) begin
                        state         <= RELEASED;
                        btn.btn_level <= 1'b0;
                    end else begin
                        db_cnt        <= db_cnt + 1'b1;
                        btn.btn_level <= 1'b1;
                    end
                end

                default: begin
                    state         <= RELEASED;
                    db_cnt        <= '0;
                    btn.btn_level <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_debounce_pulse.sv
// Self-checking bench for button_debounce_pulse: run-length reference model
// compared every cycle, plus directed latency and pulse-count scenarios.
module tb_button_debounce_pulse;

    localparam int DB   = 4;
    localparam int LONG = 20;

    logic clk = 1'b0;
    logic reset;

    button_debounce_pulse_if bif ();

    button_debounce_pulse #(
        .DB_CYCLES   (DB),
        .LONG_CYCLES (LONG),
        .CNT_W       (26)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .btn   (bif)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_press  = 0;
    int n_long   = 0;
    int n_lvl_hi = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: the accepted level flips after DB+1 consecutive synchronised
    // samples disagreeing with it; long pulse exactly LONG edges after a press
    // provided the level is still high.
    bit m_s1, m_s2, m_lvl, m_done;
    int m_run, m_since;
    bit e_press, e_long, e_lvl;

    task automatic model_step(input bit b, input bit r);
        if (r) begin
            m_s1 = 0; m_s2 = 0; m_lvl = 0; m_done = 0;
            m_run = 0; m_since = LONG + 1;
            e_press = 0; e_long = 0; e_lvl = 0;
        end else begin
            e_press = 0;
            e_long  = 0;
            if (m_s2 != m_lvl) m_run++;
            else m_run = 0;
            if (m_since <= LONG) m_since++;
            if (m_run == DB + 1) begin
                m_lvl = !m_lvl;
                m_run = 0;
                if (m_lvl) begin
                    e_press = 1;
                    m_since = 0;
                    m_done  = 0;
                end
            end
            if (m_lvl && !m_done && m_since == LONG) begin
                e_long = 1;
                m_done = 1;
            end
            e_lvl = m_lvl;
            m_s2  = m_s1;
            m_s1  = b;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            model_step(bif.btn_in, reset);
            @(negedge clk);
            check("press_pulse", 32'(bif.press_pulse), 32'(e_press));
            check("long_pulse",  32'(bif.long_pulse),  32'(e_long));
            check("btn_level",   32'(bif.btn_level),   32'(e_lvl));
            if (bif.press_pulse === 1'b1) n_press++;
            if (bif.long_pulse  === 1'b1) n_long++;
            if (bif.btn_level   === 1'b1) n_lvl_hi++;
        end
    end

    task automatic wait_for(input int which, input logic want, input int max_cyc, output int lat);
        logic v;
        lat = max_cyc + 1;
        for (int k = 1; k <= max_cyc; k++) begin
            @(posedge clk);
            @(negedge clk);
            case (which)
                0:       v = bif.press_pulse;
                1:       v = bif.long_pulse;
                default: v = bif.btn_level;
            endcase
            if (v === want) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run exceeded time limit at t=%0t", $time);
        $fatal(1, "watchdog expired");
    end

    int  lat, base_press, base_long, base_lvl, long_k, seg_len;
    bit  lvl_drop, seg_lvl, seg_noisy, seg_rst;

    initial begin
        reset      = 1'b1;
        bif.btn_in = 1'b0;

        @(negedge clk);
        check("reset_outputs", 32'({bif.press_pulse, bif.long_pulse, bif.btn_level}), 32'd0);
        repeat (2) @(posedge clk);
        #2 reset = 1'b0;
        repeat (5) @(posedge clk);

        // Clean press, long hold, single long pulse, release.
        #2 bif.btn_in = 1'b1;
        wait_for(0, 1'b1, 40, lat);
        check("t1_press_latency", lat, 7);
        check("t1_level_with_press", 32'(bif.btn_level), 32'd1);
        base_long = n_long;
        wait_for(1, 1'b1, 40, lat);
        check("t1_long_latency", lat, 20);
        repeat (10) @(posedge clk);
        #2;
        check("t1_single_long", n_long - base_long, 1);
        bif.btn_in = 1'b0;
        wait_for(2, 1'b0, 40, lat);
        check("t1_release_latency", lat, 7);
        repeat (5) @(posedge clk);

        // Bounce burst shorter than the debounce window.
        #2;
        base_press = n_press;
        base_lvl   = n_lvl_hi;
        repeat (4) begin
            bif.btn_in = 1'b1;
            repeat (3) @(posedge clk);
            #2 bif.btn_in = 1'b0;
            repeat (2) @(posedge clk);
            #2;
        end
        repeat (10) @(posedge clk);
        #2;
        check("t2_no_press", n_press - base_press, 0);
        check("t2_level_low", n_lvl_hi - base_lvl, 0);

        // Release bounce inside the hold window.
        bif.btn_in = 1'b1;
        wait_for(0, 1'b1, 40, lat);
        check("t4_press_latency", lat, 7);
        long_k   = 0;
        lvl_drop = 0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk);
            #2;
            if (k == 1) base_press = n_press;
            if (k == 5) bif.btn_in = 1'b0;
            if (k == 7) bif.btn_in = 1'b1;
            @(negedge clk);
            if (bif.long_pulse === 1'b1 && long_k == 0) long_k = k;
            if (bif.btn_level !== 1'b1) lvl_drop = 1;
        end
        check("t4_long_latency", long_k, 20);
        check("t4_level_held", 32'(lvl_drop), 32'd0);
        check("t4_no_new_press", n_press - base_press, 0);
        @(posedge clk);
        #2 bif.btn_in = 1'b0;
        repeat (12) @(posedge clk);

        // Reset while the press is being qualified.
        #2 bif.btn_in = 1'b1;
        repeat (4) @(posedge clk);
        #2 reset = 1'b1;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check("t5_reset_outputs", 32'({bif.press_pulse, bif.long_pulse, bif.btn_level}), 32'd0);
        end
        @(posedge clk);
        #2 reset = 1'b0;
        wait_for(0, 1'b1, 40, lat);
        check("t5_press_after_reset", lat, 7);
        @(posedge clk);
        #2 bif.btn_in = 1'b0;
        repeat (12) @(posedge clk);

        // Back-to-back press / release / press, 6 stable cycles each.
        #2;
        base_press = n_press;
        base_long  = n_long;
        bif.btn_in = 1'b1;
        repeat (6) @(posedge clk);
        #2 bif.btn_in = 1'b0;
        repeat (6) @(posedge clk);
        #2 bif.btn_in = 1'b1;
        repeat (6) @(posedge clk);
        #2 bif.btn_in = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        check("t6_press_count", n_press - base_press, 2);
        check("t6_long_count", n_long - base_long, 0);

        // Randomised segments: clean or noisy levels, occasional reset.
        for (int seg = 0; seg < 80; seg++) begin
            seg_len   = $urandom_range(1, 45);
            seg_lvl   = 1'($urandom_range(0, 1));
            seg_noisy = ($urandom_range(0, 3) == 0);
            seg_rst   = ($urandom_range(0, 19) == 0);
            for (int c = 0; c < seg_len; c++) begin
                bif.btn_in = (seg_noisy && $urandom_range(0, 3) == 0) ? !seg_lvl : seg_lvl;
                reset      = seg_rst && (c < 2);
                @(posedge clk);
                #2;
            end
        end
        reset      = 1'b0;
        bif.btn_in = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
